// File: rtl/sopc_run_ctrl_pkg.sv
// Shared definitions for the SOPC run controller: FSM state encoding,
// per-domain reset polarity and the default tohost address.
package sopc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

  // Width of the hold/stagger down-counter; large enough for any practical hold time.
  localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/sopc_run_ctrl_rst_stagger.sv
// Hold-then-stagger reset sequencer: a down-counter and a domain index that
// release dom_rst[0..N_DOM-1] in order and pulse release_done after the last.
module sopc_run_ctrl_rst_stagger
  import sopc_run_ctrl_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYC    = 8,
  parameter int STAGGER_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  output logic [N_DOM-1:0] dom_rst,
  output logic             first_rel,
  output logic             release_done
);

  localparam int IDX_W = $clog2(N_DOM + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
  logic             release_done_q, release_done_d;
  logic             fire;

  assign fire      = active && (tmr_q == '0) && (idx_q < IDX_W'(N_DOM));
  assign first_rel = fire && (idx_q == '0);

  always_comb begin
    tmr_d          = tmr_q;
    idx_d          = idx_q;
    dom_rst_d      = dom_rst_q;
    release_done_d = 1'b0;
    if (load) begin
      tmr_d     = TMR_W'(HOLD_CYC);
      idx_d     = '0;
      dom_rst_d = {N_DOM{RST_ENABLE}};
    end else if (fire) begin
      if (STAGGER_CYC == 0) begin
        dom_rst_d      = {N_DOM{RST_DISABLE}};
        idx_d          = IDX_W'(N_DOM);
        release_done_d = 1'b1;
      end else begin
        for (int i = 0; i < N_DOM; i++) begin
          if (i == int'(idx_q)) dom_rst_d[i] = RST_DISABLE;
        end
        idx_d          = idx_q + IDX_W'(1);
        // Reloading STAGGER_CYC-1 puts the next release exactly STAGGER_CYC edges later.
        tmr_d          = TMR_W'(STAGGER_CYC - 1);
        release_done_d = (idx_q == IDX_W'(N_DOM - 1));
      end
    end else if (active && (tmr_q != '0)) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q          <= '0;
      idx_q          <= '0;
      dom_rst_q      <= {N_DOM{RST_ENABLE}};
      release_done_q <= 1'b0;
    end else begin
      tmr_q          <= tmr_d;
      idx_q          <= idx_d;
      dom_rst_q      <= dom_rst_d;
      release_done_q <= release_done_d;
    end
  end

  assign dom_rst      = dom_rst_q;
  assign release_done = release_done_q;

endmodule

// File: rtl/sopc_run_ctrl.sv
// SOPC run controller: staggered reset release, RUN cycle counter, watchdog and
// tohost end-of-test monitor. Define SOPC_RUN_CTRL_RESTART_EN to allow restart from DONE.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYC    = 8,
  parameter int STAGGER_CYC = 2,
  parameter int TIMEOUT_CYC = 500,
  parameter int CNT_W       = 32,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_DOM-1:0]  dom_rst,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_data,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] exit_code
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-2:0] exit_code_q, exit_code_d;
  logic              load, active, first_rel, release_done, tohost_hit;

  sopc_run_ctrl_rst_stagger #(
    .N_DOM      (N_DOM),
    .HOLD_CYC   (HOLD_CYC),
    .STAGGER_CYC(STAGGER_CYC)
  ) u_rst_stagger (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .active      (active),
    .dom_rst     (dom_rst),
    .first_rel   (first_rel),
    .release_done(release_done)
  );

  assign active     = (state_q == ST_HOLD) || (state_q == ST_RELEASE);
  assign tohost_hit = mon_we && (mon_addr == TOHOST_ADDR) && mon_data[0];

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (first_rel) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (release_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        // A tohost store on the watchdog cycle takes priority over the timeout.
        if (tohost_hit) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          exit_code_d = mon_data[DATA_W-1:1];
          pass_d      = (mon_data[DATA_W-1:1] == '0);
        end else if (cycle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef SOPC_RUN_CTRL_RESTART_EN
        if (start) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      cycle_cnt_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      exit_code_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl with default parameters: reset release timing,
// tohost pass/fail, ignored stores, watchdog, tohost-vs-timeout priority, mid-run reset.
module tb_sopc_run_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  dom_rst;
  logic        mon_we;
  logic [31:0] mon_addr;
  logic [31:0] mon_data;
  logic [31:0] cycle_cnt;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] exit_code;

  int checkCount = 0;
  int failCount  = 0;

  sopc_run_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dom_rst  (dom_rst),
    .mon_we   (mon_we),
    .mon_addr (mon_addr),
    .mon_data (mon_data),
    .cycle_cnt(cycle_cnt),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .exit_code(exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one set of inputs for exactly one rising edge, then samples 1 time unit later.
  task automatic applyStimulus(input logic st, input logic we, input logic [31:0] addr, input logic [31:0] data);
    start    = st;
    mon_we   = we;
    mon_addr = addr;
    mon_data = data;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mon_we   = 1'b0;
    mon_addr = '0;
    mon_data = '0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_dom_rst"}, 64'(dom_rst), 64'h7);
    checkOutput({tag, "_cnt"}, 64'(cycle_cnt), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_exit"}, 64'(exit_code), 64'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset(input string tag);
    rst = 1'b0;
    #2;
    checkResetValues(tag);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Start edge t; dom_rst falls at t+9/t+11/t+13, RUN from t+14, returns after t+15 (cnt=1).
  task automatic runSequence(input string tag);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput({tag, "_hold_entry"}, 64'(dom_rst), 64'h7);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, (i == 3), TOHOST, 32'h1);
    checkOutput({tag, "_hold_end"}, 64'(dom_rst), 64'h7);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_rel0"}, 64'(dom_rst), 64'h6);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_rel0_hold"}, 64'(dom_rst), 64'h6);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_rel1"}, 64'(dom_rst), 64'h4);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_rel1_hold"}, 64'(dom_rst), 64'h4);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_rel2"}, 64'(dom_rst), 64'h0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_run_entry_cnt"}, 64'(cycle_cnt), 64'd0);
    checkOutput({tag, "_bus_ignored"}, 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({tag, "_run_cnt1"}, 64'(cycle_cnt), 64'd1);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    mon_we   = 1'b0;
    mon_addr = '0;
    mon_data = '0;
    #12;
    checkResetValues("por");
    #8;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(3);
    checkOutput("idle_dom_rst", 64'(dom_rst), 64'h7);

    // Pass run: tohost store on RUN cycle 40.
    runSequence("a");
    idleCycles(38);
    checkOutput("a_cnt39", 64'(cycle_cnt), 64'd39);
    checkOutput("a_not_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h1);
    checkOutput("a_done", 64'(done), 64'd1);
    checkOutput("a_pass", 64'(pass), 64'd1);
    checkOutput("a_exit", 64'(exit_code), 64'd0);
    checkOutput("a_timeout", 64'(timeout), 64'd0);
    checkOutput("a_cnt40", 64'(cycle_cnt), 64'd40);
    idleCycles(3);
    checkOutput("a_cnt_frozen", 64'(cycle_cnt), 64'd40);
    checkOutput("a_dom_rst_done", 64'(dom_rst), 64'h0);
    applyStimulus(1'b1, 1'b0, '0, '0);
`ifdef SOPC_RUN_CTRL_RESTART_EN
    checkOutput("a_restart_dom", 64'(dom_rst), 64'h7);
    checkOutput("a_restart_done", 64'(done), 64'd0);
    checkOutput("a_restart_cnt", 64'(cycle_cnt), 64'd0);
    checkOutput("a_restart_pass", 64'(pass), 64'd0);
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("a_restart_rel0", 64'(dom_rst), 64'h6);
`else
    checkOutput("a_start_in_done_dom", 64'(dom_rst), 64'h0);
    checkOutput("a_start_in_done_done", 64'(done), 64'd1);
    checkOutput("a_start_in_done_cnt", 64'(cycle_cnt), 64'd40);
    idleCycles(10);
    checkOutput("a_done_terminal_dom", 64'(dom_rst), 64'h0);
`endif

    // Fail run: ignored stores, then exit code 3.
    doReset("rst_b");
    runSequence("b");
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h6);
    checkOutput("b_data0_ignored", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_1004, 32'h1);
    checkOutput("b_addr_ignored", 64'(done), 64'd0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h7);
    checkOutput("b_done", 64'(done), 64'd1);
    checkOutput("b_pass", 64'(pass), 64'd0);
    checkOutput("b_exit", 64'(exit_code), 64'd3);
    checkOutput("b_timeout", 64'(timeout), 64'd0);
    checkOutput("b_cnt", 64'(cycle_cnt), 64'd10);

    // Watchdog after 500 RUN cycles.
    doReset("rst_c");
    runSequence("c");
    idleCycles(498);
    checkOutput("c_cnt499", 64'(cycle_cnt), 64'd499);
    checkOutput("c_not_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("c_done", 64'(done), 64'd1);
    checkOutput("c_timeout", 64'(timeout), 64'd1);
    checkOutput("c_pass", 64'(pass), 64'd0);
    checkOutput("c_exit", 64'(exit_code), 64'd0);
    checkOutput("c_cnt500", 64'(cycle_cnt), 64'd500);
    idleCycles(2);
    checkOutput("c_cnt_frozen", 64'(cycle_cnt), 64'd500);

    // Tohost store on the watchdog cycle wins.
    doReset("rst_d");
    runSequence("d");
    idleCycles(498);
    applyStimulus(1'b0, 1'b1, TOHOST, 32'h1);
    checkOutput("d_done", 64'(done), 64'd1);
    checkOutput("d_timeout", 64'(timeout), 64'd0);
    checkOutput("d_pass", 64'(pass), 64'd1);
    checkOutput("d_cnt500", 64'(cycle_cnt), 64'd500);

    // Asynchronous reset during RELEASE, then an identical sequence.
    doReset("rst_e");
    applyStimulus(1'b1, 1'b0, '0, '0);
    idleCycles(10);
    checkOutput("e_mid_release", 64'(dom_rst), 64'h6);
    doReset("e_async");
    idleCycles(2);
    checkOutput("e_idle_after_rst", 64'(dom_rst), 64'h7);
    runSequence("e_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sopc_run_ctrl.md
# sopc_run_ctrl

Parametrised run controller for the SOPC simulation and FPGA top level. It sequences reset release across N independent reset domains (core, memory, peripherals…) with a configurable hold and stagger. It runs a cycle counter with watchdog timeout and detects end-of-test from a monitored "tohost" store on the data bus, reporting done/pass/exit code. It replaces a fixed testbench reset pulse and fixed finish delay with a reusable, cycle-exact block.

## Interface
- N_DOM, 3: number of reset domains released in order 0..N_DOM-1
- HOLD_CYC, 8: cycles all domains stay in reset after start
- STAGGER_CYC, 2: cycles between consecutive domain releases (0 = release all together)
- TIMEOUT_CYC, 500: RUN-state cycles before watchdog fires
- CNT_W, 32: cycle counter width
- ADDR_W, 32 / DATA_W, 32: monitored bus widths
- TOHOST_ADDR, 32'h0000_1000: end-of-test store address

- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a run
- dom_rst  out  N_DOM  per-domain reset, active-high (`RstEnable` polarity), bit i = domain i
- mon_we  in  1  data-bus write strobe
- mon_addr  in  ADDR_W  data-bus address
- mon_data  in  DATA_W  data-bus write data
- cycle_cnt  out  CNT_W  cycles spent in RUN
- done  out  1  run finished (tohost or timeout), level
- pass  out  1  valid when done; 1 = exit code zero
- timeout  out  1  watchdog fired, level
- exit_code  out  DATA_W-1  tohost payload mon_data[DATA_W-1:1]

## Operation
- FSM states: IDLE, HOLD, RELEASE, RUN, DONE.
- IDLE: all dom_rst=1; start -> HOLD, hold counter cleared.
- HOLD: after HOLD_CYC cycles -> RELEASE.
- RELEASE: domain 0 deasserts on entry, domain k deasserts STAGGER_CYC·k cycles later. After the last domain deasserts -> RUN. With STAGGER_CYC=0, all deassert together and RUN is entered on the next cycle.
- RUN: cycle_cnt increments each cycle and saturates at all-ones (no wrap).
- RUN, tohost event: mon_we=1, mon_addr==TOHOST_ADDR, mon_data[0]=1 -> DONE. Latch exit_code; pass = (exit_code==0).
- A tohost store with mon_data[0]=0 is ignored.
- Stores to other addresses are ignored. Bus is ignored outside RUN.
- RUN, watchdog: cycle_cnt reaches TIMEOUT_CYC-1 without a tohost event -> DONE with timeout=1, pass=0, exit_code=0.
- Tohost event and timeout in the same cycle: tohost wins, timeout=0.
- DONE: dom_rst stays deasserted, outputs hold. start is ignored unless configured otherwise (see Configuration).
- start outside IDLE (and outside DONE in restart mode) is ignored.

## Timing
- Reset (rst=0, async): state=IDLE, dom_rst=all ones, cycle_cnt=0, done=0, pass=0, timeout=0, exit_code=0.
- rst mid-run: immediate return to reset values. No output glitches to 0 on dom_rst.
- All outputs are registered.
- start at edge t -> HOLD at t+1. dom_rst[0] falls at t+1+HOLD_CYC. dom_rst[i] falls at t+1+HOLD_CYC+i·STAGGER_CYC.
- First RUN cycle: one cycle after dom_rst[N_DOM-1] falls. cycle_cnt=1 at the end of that cycle.
- Tohost store sampled at edge e -> done, pass, exit_code valid at e+1.
- cycle_cnt freezes at the value it had on the detecting edge.

## Configuration
- SOPC_RUN_CTRL_RESTART_EN defined: start in DONE reasserts all dom_rst, clears cycle_cnt, done, pass, timeout, exit_code, and enters HOLD next cycle, identical to the start from IDLE.
- Not defined: DONE is terminal until rst.

## Structure
- Shared package/defs: FSM state encoding (3-bit localparams), and a default TOHOST_ADDR constant in defs.v alongside `RstEnable/`RstDisable.
- One sub-module, rst_stagger: a down-counter plus domain index that produces the dom_rst vector and a release_done pulse, given HOLD_CYC/STAGGER_CYC/N_DOM.
- The top holds the FSM, cycle counter, watchdog, and tohost monitor.

## Test plan
- N_DOM=3, HOLD_CYC=8, STAGGER_CYC=2, start at cycle 5 -> dom_rst falls at cycles 14/16/18. RUN begins at 19.
- Store mon_data=32'h1 to TOHOST_ADDR in cycle 40 of RUN -> done=1, pass=1, exit_code=0, cycle_cnt=40 next cycle.
- Store 32'h7 (exit code 3) -> pass=0, exit_code=3. A prior store of 32'h6 and a store of 32'h1 to 0x1004 are both ignored.
- No store, TIMEOUT_CYC=500 -> done=timeout=1 after 500 RUN cycles, pass=0. A tohost store landing exactly on cycle 500 -> timeout=0, pass=1.
- rst pulsed low during RELEASE -> all dom_rst=1 asynchronously, state IDLE. A later start repeats the exact sequence.
- With SOPC_RUN_CTRL_RESTART_EN: start in DONE -> outputs cleared, new sequence matches the first. Without it: start in DONE -> no change.
